// File: rtl/seg7_capture.sv
// Recovers per-digit hex values from a multiplexed, active-low 7-segment bus.
// The bus is double-registered, qualified by a stability count, then decoded.
module seg7_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an,
  input  logic [6:0]            seg,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     valid,
  output logic [DIGITS-1:0]     err,
  output logic                  upd,
  output logic [2:0]            upd_idx,
  output logic                  multi
);

  localparam int BW = DIGITS + 7;
  localparam int CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);

  logic [BW-1:0]         s1_q, s2_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   value_q, value_d;
  logic [DIGITS-1:0]     valid_q, valid_d;
  logic [DIGITS-1:0]     err_q, err_d;
  logic                  upd_q, upd_d;
  logic [2:0]            upd_idx_q, upd_idx_d;
  logic                  multi_q, multi_d;

  logic [DIGITS-1:0]     an_s;
  logic [6:0]            seg_s;
  logic [3:0]            n_low;
  logic [2:0]            low_idx;
  logic                  stable_hit;
  logic                  capture;
  logic [3:0]            dec_val;
  logic                  dec_err;

  assign an_s  = s2_q[BW-1:7];
  assign seg_s = s2_q[6:0];

  // Segment order is {CA..CG}, active-low; unknown patterns read back as F with err.
  function automatic logic [4:0] decode7(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b0000001: r = {1'b0, 4'h0};
      7'b1001111: r = {1'b0, 4'h1};
      7'b0010010: r = {1'b0, 4'h2};
      7'b0000110: r = {1'b0, 4'h3};
      7'b1001100: r = {1'b0, 4'h4};
      7'b0100100: r = {1'b0, 4'h5};
      7'b0100000: r = {1'b0, 4'h6};
      7'b0001111: r = {1'b0, 4'h7};
      7'b0000000: r = {1'b0, 4'h8};
      7'b0001100: r = {1'b0, 4'h9};
      7'b0001000: r = {1'b0, 4'hA};
      7'b1100000: r = {1'b0, 4'hB};
      7'b0110001: r = {1'b0, 4'hC};
      7'b1000010: r = {1'b0, 4'hD};
      7'b0110000: r = {1'b0, 4'hE};
      7'b0111000: r = {1'b0, 4'hF};
      default:    r = {1'b1, 4'hF};
    endcase
    return r;
  endfunction

  always_comb begin
    n_low   = 4'd0;
    low_idx = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_s[i]) begin
        n_low   = n_low + 4'd1;
        low_idx = 3'(i);
      end
    end
  end

  assign {dec_err, dec_val} = decode7(seg_s);

  // cnt passes through STABLE_CYCLES-1 only once per interval, so at most one capture.
  assign stable_hit = (s1_q == s2_q) && (cnt_q == CW'(STABLE_CYCLES - 1));
  assign capture    = stable_hit && (n_low == 4'd1);

  always_comb begin
    cnt_d     = cnt_q;
    value_d   = value_q;
    valid_d   = valid_q;
    err_d     = err_q;
    upd_d     = 1'b0;
    upd_idx_d = 3'd0;
    multi_d   = multi_q;

    if (s1_q != s2_q)
      cnt_d = '0;
    else if (cnt_q < CW'(STABLE_CYCLES))
      cnt_d = cnt_q + CW'(1);

    if (capture) begin
      upd_d     = 1'b1;
      upd_idx_d = low_idx;
      for (int i = 0; i < DIGITS; i++) begin
        if (low_idx == 3'(i)) begin
          value_d[4*i +: 4] = dec_val;
          valid_d[i]        = 1'b1;
          err_d[i]          = dec_err;
        end
      end
    end

    if (stable_hit && (n_low > 4'd1))
      multi_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '1;
      s2_q      <= '1;
      cnt_q     <= '0;
      value_q   <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= 3'd0;
      multi_q   <= 1'b0;
    end else begin
      s1_q      <= {an, seg};
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
      multi_q   <= multi_d;
    end
  end

  assign value   = value_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign upd     = upd_q;
  assign upd_idx = upd_idx_q;
  assign multi   = multi_q;

endmodule
